mdio_phy_regfile: RTL and testbench
===================================

MDIO_PHY_REGFILE -- requirements
Module: mdio_phy_regfile

Interface
REQ-001 Parameter PHY_ADDR, default 5'd8: PHY address this block answers to.
REQ-002 Parameter NUM_REGS, default 32, range 1..32: number of implemented 16-bit registers.
REQ-003 Parameter BCAST_EN, default 1: PHYAD 5'd0 is also accepted for writes; reads to PHYAD 0 are ignored.
REQ-004 MDC  input  1: the single clock; all logic on rising edge.
REQ-005 reset  input  1: asynchronous, active-low reset.
REQ-006 MDIO_OUT  input  1: serial data driven by the controller.
REQ-007 MDIO_OE  input  1: controller output enable; MDIO_OUT is valid only while high.
REQ-008 MDIO_IN  output  1: serial read data returned to the controller.
REQ-009 ADDR  output  5: register address of the last accepted frame.
REQ-010 WR_DATA  output  16: data of the last accepted write.
REQ-011 WR_STB  output  1: one-cycle pulse when a register is written.
REQ-012 MDIO_DONE  output  1: one-cycle pulse at the end of every accepted frame.

Function
REQ-013 Frame: ST(2)=01, OP(2), PHYAD(5), REGAD(5), TA(2), DATA(16); all fields MSB first, one bit per MDC rising edge.
REQ-014 Bits are sampled only when MDIO_OE=1; in IDLE, 1s (preamble) are ignored and a sampled 0 moves the FSM to ST.
REQ-015 States: IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, IGNORE; a 5-bit bit counter times each field.
REQ-016 ST: a sampled 1 moves the FSM to OP; a sampled 0 stays in ST.
REQ-017 OP=01 is write and OP=10 is read; OP=00 or 11 moves the FSM to IGNORE.
REQ-018 Address match after REGAD: PHYAD==PHY_ADDR, or (BCAST_EN and PHYAD==0 and write); no match moves the FSM to IGNORE.
REQ-019 TA lasts exactly 2 cycles and its values are not checked; MDIO_OE is ignored during TA of a read.
REQ-020 Write: after 16 WDATA bits, if REGAD<NUM_REGS then regs[REGAD]<=data, WR_DATA<=data, and WR_STB=1 and MDIO_DONE=1 in the same cycle; if REGAD>=NUM_REGS, only MDIO_DONE pulses.
REQ-021 Read: MDIO_IN is registered; it carries bit 15 of regs[REGAD] in the first cycle after TA, then one bit per cycle for 16 cycles (0 if REGAD>=NUM_REGS); MDIO_DONE pulses in the cycle after the last bit.
REQ-022 MDIO_IN=0 in all states outside RDATA.
REQ-023 ADDR is updated at the end of REGAD on an address match only; it holds otherwise.
REQ-024 MDIO_OE falling during ST..REGAD or WDATA aborts to IDLE: no write, no strobes.
REQ-025 RDATA completes all 16 bits regardless of MDIO_OE.
REQ-026 IGNORE returns to IDLE on the first cycle with MDIO_OE=0; MDIO_IN stays 0 and no strobes are issued.
REQ-027 From end-of-frame, the FSM returns to IDLE; a new ST is accepted in the next cycle.

Reset
REQ-028 When reset=0, immediately: state IDLE, counter 0, all registers 16'h0000, MDIO_IN/WR_STB/MDIO_DONE 0, ADDR 0, WR_DATA 0.
REQ-029 Reset asserted mid-frame discards the frame: no write, no pulse after release.
REQ-030 After reset is released, the first sampled 0 with MDIO_OE=1 starts a frame.

Structure
REQ-031 A shared package holds the FSM state encoding, opcode constants (OP_WR=2'b01, OP_RD=2'b10), ST constant 2'b01 and field widths.
REQ-032 The register file is the single sub-module mdio_regfile: NUM_REGS x 16, one write port, one combinational read port, async active-low clear.

Verification
REQ-033 Write PHYAD=8, REGAD=20, data 16'h5555 -> WR_STB and MDIO_DONE pulse together, ADDR=20, WR_DATA=16'h5555, regs[20]=16'h5555.
REQ-034 Read PHYAD=8, REGAD=20 after REQ-033 -> MDIO_IN serialises 0,1,0,1,...,0,1 (16'h5555, MSB first) in the 16 cycles after TA, then MDIO_DONE pulses once.
REQ-035 Write PHYAD=3, data 16'hFFFF -> no WR_STB, no MDIO_DONE, regs unchanged; then a write to PHYAD=0, REGAD=2, data 16'h1234 -> regs[2]=16'h1234.
REQ-036 With NUM_REGS=16: write REGAD=20 -> MDIO_DONE only, no WR_STB; read REGAD=20 -> MDIO_IN all 0.
REQ-037 Drop MDIO_OE after 8 WDATA bits, or pulse reset low mid-frame -> no WR_STB; a following valid write to REGAD=1 with data 16'hA5A5 succeeds.
REQ-038 OP=11 frame, then a valid frame after MDIO_OE goes low -> first frame ignored, second accepted.

Source files
------------

// File: rtl/mdio_phy_regfile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdio_phy_regfile_pkg : shared FSM encoding, MDIO frame constants and widths
// rev 1.0
// ---------------------------------------------------------------------------
package mdio_phy_regfile_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ST     = 4'd1,
        S_OP     = 4'd2,
        S_PHYAD  = 4'd3,
        S_REGAD  = 4'd4,
        S_TA     = 4'd5,
        S_WDATA  = 4'd6,
        S_RDATA  = 4'd7,
        S_IGNORE = 4'd8
    } state_t;

    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_RD   = 2'b10;
    localparam logic [1:0] ST_CODE = 2'b01;

    localparam int OP_W    = 2;
    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int TA_W    = 2;
    localparam int DATA_W  = 16;

    // Index of the last bit of the field timed by the bit counter in state s.
    function automatic logic [4:0] field_last(input state_t s);
        case (s)
            S_OP:             return 5'(OP_W - 1);
            S_PHYAD:          return 5'(PHYAD_W - 1);
            S_REGAD:          return 5'(REGAD_W - 1);
            S_TA:             return 5'(TA_W - 1);
            S_WDATA, S_RDATA: return 5'(DATA_W - 1);
            default:          return 5'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdio_regfile : NUM_REGS x 16 register file, one write port, comb read port
// rev 1.0
// ---------------------------------------------------------------------------
module mdio_regfile
    import mdio_phy_regfile_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [REGAD_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [REGAD_W-1:0]   raddr_i,
    output logic [DATA_W-1:0]    rdata_o
);

    // Full 32-entry read map; unimplemented addresses read as zero.
    logic [DATA_W-1:0] rd_arr [32];

    for (genvar i = 0; i < 32; i++) begin : g_reg
        if (i < NUM_REGS) begin : g_impl
            logic [DATA_W-1:0] reg_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    reg_q <= '0;
                end else if (we_i && (waddr_i == 5'(i))) begin
                    reg_q <= wdata_i;
                end
            end
            assign rd_arr[i] = reg_q;
        end else begin : g_absent
            assign rd_arr[i] = '0;
        end
    end

    assign rdata_o = rd_arr[raddr_i];

endmodule
`default_nettype wire

// File: rtl/mdio_phy_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mdio_phy_regfile : MDIO clause-22 slave frame decoder with PHY register file
// rev 1.0
// ---------------------------------------------------------------------------
module mdio_phy_regfile
    import mdio_phy_regfile_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd8,
    parameter int         NUM_REGS = 32,
    parameter bit         BCAST_EN = 1'b1
) (
    input  logic                 MDC,
    input  logic                 reset,
    input  logic                 MDIO_OUT,
    input  logic                 MDIO_OE,
    output logic                 MDIO_IN,
    output logic [REGAD_W-1:0]   ADDR,
    output logic [DATA_W-1:0]    WR_DATA,
    output logic                 WR_STB,
    output logic                 MDIO_DONE
);

    localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);

    state_t               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [DATA_W-1:0]    sh_q, sh_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic [PHYAD_W-1:0]   phyad_q, phyad_d;
    logic [REGAD_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic                 mdio_in_q, mdio_in_d;
    logic                 wr_stb_q, wr_stb_d;
    logic                 done_q, done_d;

    logic [DATA_W-1:0]    w_shift;
    logic [DATA_W-1:0]    w_rdata;
    logic                 w_we;
    logic                 w_match;
    logic                 w_in_range;

    assign w_shift    = {sh_q[DATA_W-2:0], MDIO_OUT};
    assign w_in_range = ({1'b0, addr_q} < NUM_REGS_W);
    // Broadcast address is write-only: a read to PHYAD 0 must stay silent.
    assign w_match    = (phyad_q == PHY_ADDR) ||
                        (BCAST_EN && (phyad_q == '0) && (op_q == OP_WR));

    mdio_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk_i    (MDC),
        .rst_ni   (reset),
        .we_i     (w_we),
        .waddr_i  (addr_q),
        .wdata_i  (w_shift),
        .raddr_i  (addr_q),
        .rdata_o  (w_rdata)
    );

    always_ff @(posedge MDC or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            op_q      <= '0;
            phyad_q   <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            mdio_in_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            op_q      <= op_d;
            phyad_q   <= phyad_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            mdio_in_q <= mdio_in_d;
            wr_stb_q  <= wr_stb_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        op_d      = op_q;
        phyad_d   = phyad_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        mdio_in_d = 1'b0;
        wr_stb_d  = 1'b0;
        done_d    = 1'b0;
        w_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MDIO_OE && (MDIO_OUT == ST_CODE[1])) begin
                    state_d = S_ST;
                end
            end
            S_ST: begin
                if (!MDIO_OE) begin
                    state_d = S_IDLE;
                end else if (MDIO_OUT == ST_CODE[0]) begin
                    state_d = S_OP;
                    cnt_d   = '0;
                end
            end
            S_OP, S_PHYAD, S_REGAD, S_WDATA: begin
                if (!MDIO_OE) begin
                    state_d = S_IDLE;
                end else begin
                    sh_d  = w_shift;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == field_last(state_q)) begin
                        cnt_d = '0;
                        case (state_q)
                            S_OP: begin
                                op_d    = w_shift[OP_W-1:0];
                                state_d = ((w_shift[OP_W-1:0] == OP_WR) ||
                                           (w_shift[OP_W-1:0] == OP_RD)) ? S_PHYAD : S_IGNORE;
                            end
                            S_PHYAD: begin
                                phyad_d = w_shift[PHYAD_W-1:0];
                                state_d = S_REGAD;
                            end
                            S_REGAD: begin
                                if (w_match) begin
                                    addr_d  = w_shift[REGAD_W-1:0];
                                    state_d = S_TA;
                                end else begin
                                    state_d = S_IGNORE;
                                end
                            end
                            default: begin
                                done_d  = 1'b1;
                                state_d = S_IDLE;
                                if (w_in_range) begin
                                    w_we      = 1'b1;
                                    wr_stb_d  = 1'b1;
                                    wr_data_d = w_shift;
                                end
                            end
                        endcase
                    end
                end
            end
            S_TA: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == field_last(S_TA)) begin
                    cnt_d = '0;
                    if (op_q == OP_WR) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d   = S_RDATA;
                        mdio_in_d = w_rdata[DATA_W-1];
                    end
                end
            end
            S_RDATA: begin
                // Read data is shifted out regardless of MDIO_OE.
                if (cnt_q == field_last(S_RDATA)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d     = cnt_q + 5'd1;
                    mdio_in_d = w_rdata[4'd14 - cnt_q[3:0]];
                end
            end
            S_IGNORE: begin
                if (!MDIO_OE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign MDIO_IN   = mdio_in_q;
    assign ADDR      = addr_q;
    assign WR_DATA   = wr_data_q;
    assign WR_STB    = wr_stb_q;
    assign MDIO_DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mdio_phy_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mdio_phy_regfile : random + directed MDIO frames against a frame-level model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_mdio_phy_regfile;

    logic        MDC = 1'b0;
    logic        reset;
    logic        MDIO_OUT = 1'b0;
    logic        MDIO_OE  = 1'b0;

    logic        in_a, stb_a, done_a;
    logic [4:0]  addr_a;
    logic [15:0] wd_a;
    logic        in_b, stb_b, done_b;
    logic [4:0]  addr_b;
    logic [15:0] wd_b;

    always #5 MDC = ~MDC;

    mdio_phy_regfile dut (
        .MDC       (MDC),
        .reset     (reset),
        .MDIO_OUT  (MDIO_OUT),
        .MDIO_OE   (MDIO_OE),
        .MDIO_IN   (in_a),
        .ADDR      (addr_a),
        .WR_DATA   (wd_a),
        .WR_STB    (stb_a),
        .MDIO_DONE (done_a)
    );

    mdio_phy_regfile #(.NUM_REGS(16)) dut16 (
        .MDC       (MDC),
        .reset     (reset),
        .MDIO_OUT  (MDIO_OUT),
        .MDIO_OE   (MDIO_OE),
        .MDIO_IN   (in_b),
        .ADDR      (addr_b),
        .WR_DATA   (wd_b),
        .WR_STB    (stb_b),
        .MDIO_DONE (done_b)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    int          frame_id = 0;
    int          nregs [2] = '{32, 16};
    logic [15:0] mreg  [2][32];
    logic [4:0]  m_addr [2];
    logic [15:0] m_wd   [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic get_obs(input int k, output logic o_in, output logic o_stb,
                           output logic o_done, output logic [4:0] o_addr,
                           output logic [15:0] o_wd);
        if (k == 0) begin
            o_in = in_a; o_stb = stb_a; o_done = done_a; o_addr = addr_a; o_wd = wd_a;
        end else begin
            o_in = in_b; o_stb = stb_b; o_done = done_b; o_addr = addr_b; o_wd = wd_b;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) mreg[k][r] = 16'h0000;
            m_addr[k] = 5'd0;
            m_wd[k]   = 16'h0000;
        end
    endtask

    task automatic cyc(input logic oe, input logic b);
        @(negedge MDC);
        MDIO_OE  = oe;
        MDIO_OUT = oe ? b : 1'($urandom);
        @(posedge MDC);
        #1;
    endtask

    // n cycles of preamble (oe=1, ones) or bus idle (oe=0); no output may move.
    task automatic quiet(input int n, input logic oe);
        int noise [2];
        logic i_, s_, d_;
        logic [4:0] a_;
        logic [15:0] w_;
        noise = '{0, 0};
        for (int c = 0; c < n; c++) begin
            cyc(oe, 1'b1);
            for (int k = 0; k < 2; k++) begin
                get_obs(k, i_, s_, d_, a_, w_);
                noise[k] += int'(i_) + int'(s_) + int'(d_);
            end
        end
        if (n > 0) begin
            for (int k = 0; k < 2; k++)
                chk($sformatf("quiet.f%0d.%0d", frame_id, k), noise[k], 0);
        end
    endtask

    task automatic run_frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [15:0] data, input int abort_at);
        logic [31:0] fr;
        int          stb_n [2], stb_p [2], done_n [2], done_p [2], stray [2];
        logic [15:0] rd [2];
        logic        i_, s_, d_, oe;
        logic [4:0]  a_;
        logic [15:0] w_;
        bit          is_rd, match, aborted;
        int          exp_stb, exp_done;
        logic [15:0] exp_rd;
        string       tag;

        fr    = {2'b01, op, phy, ra, 2'b10, data};
        is_rd = (op == 2'b10);
        for (int k = 0; k < 2; k++) begin
            stb_n[k] = 0; stb_p[k] = -1; done_n[k] = 0; done_p[k] = -1; stray[k] = 0; rd[k] = '0;
        end
        for (int p = 0; p < 32; p++) begin
            oe = !((abort_at >= 0 && p >= abort_at) || (is_rd && p >= 14));
            cyc(oe, fr[31-p]);
            for (int k = 0; k < 2; k++) begin
                get_obs(k, i_, s_, d_, a_, w_);
                if (s_) begin stb_n[k]++;  stb_p[k]  = p; end
                if (d_) begin done_n[k]++; done_p[k] = p; end
                if (p >= 15 && p <= 30) rd[k] = {rd[k][14:0], i_};
                else if (i_) stray[k]++;
            end
        end

        match   = (op == 2'b01 || op == 2'b10) && (phy == 5'd8 || (phy == 5'd0 && op == 2'b01));
        aborted = (abort_at >= 0);
        for (int k = 0; k < 2; k++) begin
            exp_stb = 0; exp_done = 0; exp_rd = 16'h0000;
            if (match && (!aborted || abort_at >= 14)) m_addr[k] = ra;
            if (match && !aborted) begin
                exp_done = 1;
                if (is_rd) begin
                    if (int'(ra) < nregs[k]) exp_rd = mreg[k][ra];
                end else if (int'(ra) < nregs[k]) begin
                    exp_stb     = 1;
                    mreg[k][ra] = data;
                    m_wd[k]     = data;
                end
            end
            get_obs(k, i_, s_, d_, a_, w_);
            tag = $sformatf("f%0d.%0d", frame_id, k);
            chk({tag, ".stb_n"},  stb_n[k],  exp_stb);
            chk({tag, ".stb_p"},  stb_p[k],  exp_stb  != 0 ? 31 : -1);
            chk({tag, ".done_n"}, done_n[k], exp_done);
            chk({tag, ".done_p"}, done_p[k], exp_done != 0 ? 31 : -1);
            chk({tag, ".rd"},     rd[k],     exp_rd);
            chk({tag, ".stray"},  stray[k],  0);
            chk({tag, ".addr"},   a_,        m_addr[k]);
            chk({tag, ".wdata"},  w_,        m_wd[k]);
        end
        frame_id++;
    endtask

    task automatic reset_mid();
        logic [31:0] fr;
        logic        i_, s_, d_;
        logic [4:0]  a_;
        logic [15:0] w_;
        fr = {2'b01, 2'b01, 5'd8, 5'd5, 2'b10, 16'hBEEF};
        for (int p = 0; p < 22; p++) cyc(1'b1, fr[31-p]);
        @(negedge MDC);
        MDIO_OE = 1'b0;
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            get_obs(k, i_, s_, d_, a_, w_);
            chk($sformatf("rstmid.%0d.out", k), {i_, s_, d_}, 3'b000);
            chk($sformatf("rstmid.%0d.addr", k), a_, 5'd0);
            chk($sformatf("rstmid.%0d.wdata", k), w_, 16'h0000);
        end
        model_clear();
        repeat (2) @(posedge MDC);
        @(negedge MDC);
        reset = 1'b1;
        quiet(12, 1'b0);
    endtask

    initial begin
        logic        i_, s_, d_;
        logic [4:0]  a_;
        logic [15:0] w_;
        logic [1:0]  op;
        logic [4:0]  phy, ra;
        int          r, ab, gap;
        bit          clean;

        model_clear();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            get_obs(k, i_, s_, d_, a_, w_);
            chk($sformatf("rst.%0d.out", k), {i_, s_, d_}, 3'b000);
            chk($sformatf("rst.%0d.addr", k), a_, 5'd0);
            chk($sformatf("rst.%0d.wdata", k), w_, 16'h0000);
        end
        repeat (3) @(posedge MDC);
        @(negedge MDC);
        reset = 1'b1;
        quiet(3, 1'b0);
        quiet(4, 1'b1);

        // Write/read of register 20 (out of range for the 16-register instance)
        run_frame(2'b01, 5'd8, 5'd20, 16'h5555, -1);
        run_frame(2'b10, 5'd8, 5'd20, 16'h0000, -1);
        // Foreign PHY ignored, broadcast write accepted, broadcast read ignored
        run_frame(2'b01, 5'd3, 5'd2, 16'hFFFF, -1);
        quiet(1, 1'b0);
        run_frame(2'b01, 5'd0, 5'd2, 16'h1234, -1);
        run_frame(2'b10, 5'd0, 5'd2, 16'h0000, -1);
        quiet(1, 1'b0);
        run_frame(2'b10, 5'd8, 5'd2, 16'h0000, -1);
        // Abort after 8 data bits, then a good write
        run_frame(2'b01, 5'd8, 5'd1, 16'h1111, 24);
        run_frame(2'b01, 5'd8, 5'd1, 16'hA5A5, -1);
        run_frame(2'b10, 5'd8, 5'd1, 16'h0000, -1);
        // Reset mid-frame, then a good write
        reset_mid();
        run_frame(2'b01, 5'd8, 5'd1, 16'hA5A5, -1);
        run_frame(2'b10, 5'd8, 5'd1, 16'h0000, -1);
        run_frame(2'b10, 5'd8, 5'd2, 16'h0000, -1);
        // Reserved opcode ignored until OE drops
        run_frame(2'b11, 5'd8, 5'd4, 16'h0F0F, -1);
        quiet(2, 1'b0);
        run_frame(2'b01, 5'd8, 5'd4, 16'h0F0F, -1);

        for (int f = 0; f < 60; f++) begin
            r   = $urandom_range(0, 9);
            op  = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            r   = $urandom_range(0, 5);
            phy = (r < 3) ? 5'd8 : (r == 3) ? 5'd0 : 5'($urandom);
            ra  = ($urandom_range(0, 3) == 0) ? 5'd20 : 5'($urandom);
            ab  = -1;
            if ($urandom_range(0, 7) == 0) begin
                if (op == 2'b10 || $urandom_range(0, 1) == 0) ab = $urandom_range(0, 13);
                else ab = $urandom_range(16, 31);
            end
            quiet($urandom_range(0, 3), 1'b1);
            run_frame(op, phy, ra, 16'($urandom), ab);
            clean = (ab < 0) && (op == 2'b01 || op == 2'b10) &&
                    (phy == 5'd8 || (phy == 5'd0 && op == 2'b01));
            gap = clean ? $urandom_range(0, 2) : $urandom_range(1, 2);
            quiet(gap, 1'b0);
        end

        // Back-to-back readback of every address
        for (int a = 0; a < 32; a++) run_frame(2'b10, 5'd8, 5'(a), 16'h0000, -1);
        quiet(2, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
